mem_wr_ctrl: RTL and testbench
==============================

# mem_wr_ctrl

Write controller for the accumulator memory. It captures the skewed result stream leaving the bottom of the systolic array, where column j's data trails column j-1 by one cycle, and produces per-column write enables and addresses so that row r of every column lands at `base_addr + r`. It is the write-side counterpart of the accumulator read controller and sits between the systolic array output edge and the per-column accumulator banks.

## Interface
- `SYS_ROW`, 16, systolic array rows (informational; no logic depends on it)
- `SYS_COL`, 16, systolic array columns = number of accumulator banks
- `DATA_WIDTH`, 16, width of `num_row`
- `ACCUM_SIZE`, 4096, total accumulator entries
- `ADDR_WIDTH`, 8, bank address width
- localparam `ACCUM_ROW` = `ACCUM_SIZE/SYS_COL` (256); `COUNT_WIDTH` = `$clog2(ACCUM_ROW)+1`

Ports:
- `clk`  in  1  clock; all logic on posedge
- `rst`  in  1  asynchronous, active-high reset
- `wr_start`  in  1  start pulse; accepted only in IDLE
- `num_row`  in  DATA_WIDTH  rows to write; sampled on accepted `wr_start`
- `base_addr`  in  ADDR_WIDTH  first row address; sampled on accepted `wr_start`
- `acc_mode`  in  1  1 = bank accumulates, 0 = bank overwrites; sampled on accepted `wr_start`
- `col0_valid`  in  1  array column-0 output valid this cycle
- `wr_en_out`  out  SYS_COL  per-bank write enable
- `wr_acc`  out  SYS_COL  per-bank accumulate qualifier; equals `wr_en_out & {SYS_COL{acc_mode_q}}`
- `wr_addr[0:SYS_COL-1]`  out  ADDR_WIDTH each  per-bank write address
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  one-cycle completion pulse
- `ovf`  out  1  sticky: `col0_valid` seen in DRAIN; cleared by the next accepted `wr_start`

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE + `wr_start`: latch `eff_rows` = min(`num_row`, `ACCUM_ROW`), `base_addr`, and `acc_mode`. Clear `ovf`, the row counter, and the skew register. Load every `wr_addr[j]` with `base_addr`.
  - If `eff_rows` = 0, stay in IDLE and pulse `done` next cycle.
  - Otherwise go to RUN.
- RUN: each cycle, inject bit `col0_valid && cnt < eff_rows` into skew register bit 0. The register shifts by one column per cycle, and bit j drives `wr_en_out[j]`. On an injection, `cnt` increments.
  - Gaps in `col0_valid` propagate as bubbles. They do not stall the controller.
  - When `cnt` reaches `eff_rows`, go to DRAIN.
- DRAIN: inject 0 each cycle. When the skew register becomes all-zero, go to IDLE, pulse `done`, and set all `wr_addr` to all-ones.
- `wr_addr[j]` increments by 1 (mod 2^ADDR_WIDTH) in the cycle after each `wr_en_out[j]` cycle. During the r-th write of column j it equals `base_addr + r` (wrapping).
- Ignored inputs:
  - `wr_start` in RUN/DRAIN is ignored.
  - `col0_valid` in IDLE is ignored, including the `wr_start` cycle.
  - `col0_valid` in DRAIN is dropped and sets `ovf`.

## Timing
- Reset values: `wr_en_out`=0, `wr_acc`=0, `wr_addr`=all-ones, `busy`=0, `done`=0, `ovf`=0, state IDLE.
- All outputs are registered.
- `col0_valid` sampled at edge k produces `wr_en_out[j]` high in the cycle after edge k+j.
- With continuous valid from edge k and N rows:
  - `wr_en_out[0]` is high in cycles k..k+N-1.
  - `wr_en_out[SYS_COL-1]` is high in cycles k+SYS_COL-1..k+SYS_COL+N-2.
  - `done` fires in cycle k+SYS_COL+N-1, and `busy` falls in the same cycle.
- `busy` rises in the cycle after an accepted `wr_start` (eff_rows>0).
- Reset mid-run: immediate return to reset values. No `done`, no further writes.
- Counter width: `cnt` is COUNT_WIDTH bits and holds `ACCUM_ROW` without overflow. Address arithmetic is modulo 2^ADDR_WIDTH.

## Structure
- Shared package `mem_pkg`: `ADDR_WIDTH` default, `mem_wr_state_e` enum (IDLE, RUN, DRAIN), all-ones idle address constant. The read controller uses the same constant.
- One sub-module, `mem_skew_sreg`: a SYS_COL-bit shift register with serial input, parallel output, synchronous clear, and async reset. It is reusable by the read side.

## Test plan
- num_row=4, base=0x00, acc_mode=0, `col0_valid` high for 4 cycles from edge k -> `wr_en_out[0]` cycles k..k+3 at addrs 0,1,2,3; `wr_en_out[15]` cycles k+15..k+18; `done` at k+19; `wr_acc`=0 throughout.
- num_row=3, acc_mode=1, valid pattern 1,0,1,1 -> each column writes addrs 0,_,1,2 with a one-cycle bubble, skewed per column; `wr_acc`==`wr_en_out`.
- num_row=0 -> no `wr_en_out`, `busy` stays 0, `done` one cycle after `wr_start`.
- num_row=300, base=0xF0, continuous valid -> exactly 256 writes per column; addresses 0xF0..0xFF then wrap 0x00..0xEF; extra valid cycles set `ovf`=1.
- `rst` asserted mid-RUN after 5 rows -> outputs return to reset values immediately; no `done`; a new `wr_start` runs cleanly with `ovf`=0.
- `wr_start` reasserted during RUN with num_row=9 -> ignored; the original row count and base are kept.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the accumulator memory read/write controllers.
package mem_pkg;

    localparam int MEM_ADDR_WIDTH = 8;

    // Address parked on every bank port while a controller is idle.
    localparam logic [MEM_ADDR_WIDTH-1:0] MEM_IDLE_ADDR = {MEM_ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } mem_wr_state_e;

endpackage

// File: rtl/mem_wr_ctrl_if.sv
// Command, status and per-bank write port bundle of the accumulator write controller.
interface mem_wr_ctrl_if
    import mem_pkg::*;
#(
    parameter int SYS_COL    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
);

    logic                  wr_start;
    logic [DATA_WIDTH-1:0] num_row;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  acc_mode;
    logic                  col0_valid;
    logic [SYS_COL-1:0]    wr_en_out;
    logic [SYS_COL-1:0]    wr_acc;
    logic [ADDR_WIDTH-1:0] wr_addr [0:SYS_COL-1];
    logic                  busy;
    logic                  done;
    logic                  ovf;

    modport master (
        output wr_start, num_row, base_addr, acc_mode, col0_valid,
        input  wr_en_out, wr_acc, wr_addr, busy, done, ovf
    );

    modport slave (
        input  wr_start, num_row, base_addr, acc_mode, col0_valid,
        output wr_en_out, wr_acc, wr_addr, busy, done, ovf
    );

endinterface

// File: rtl/mem_skew_sreg.sv
// Serial-in/parallel-out skew register: bit j is the serial input delayed by j+1 cycles.
module mem_skew_sreg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sreg_r;

    // Shift one column per cycle; synchronous clear wins over the shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            sreg_r <= {WIDTH{1'b0}};
        end else begin
            sreg_r <= {sreg_r[WIDTH-2:0], din};
        end
    end

    assign q = sreg_r;

endmodule

// File: rtl/mem_wr_ctrl.sv
// Accumulator write controller: de-skews the systolic array output stream into per-bank writes.
module mem_wr_ctrl
    import mem_pkg::*;
#(
    parameter int SYS_ROW    = 16,
    parameter int SYS_COL    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ACCUM_SIZE = 4096,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    mem_wr_ctrl_if.slave  bus
);

    localparam int ACCUM_ROW   = ACCUM_SIZE / SYS_COL;
    localparam int COUNT_WIDTH = $clog2(ACCUM_ROW) + 1;

    // The skew register needs at least two columns and the row count must fit num_row.
    if (SYS_ROW < 1 || SYS_COL < 2 || DATA_WIDTH < COUNT_WIDTH) begin : g_bad_params
        $error("mem_wr_ctrl: unsupported parameter combination");
    end

    mem_wr_state_e state_r;
    mem_wr_state_e state_s;

    logic [COUNT_WIDTH-1:0] cnt_r;
    logic [COUNT_WIDTH-1:0] eff_rows_r;
    logic [COUNT_WIDTH-1:0] eff_rows_s;
    logic                   acc_mode_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   ovf_r;
    logic [SYS_COL-1:0]     wr_acc_r;
    logic [ADDR_WIDTH-1:0]  addr_r [0:SYS_COL-1];

    logic                   accept_s;
    logic                   inj_s;
    logic                   finish_s;
    logic                   done_s;
    logic [SYS_COL-1:0]     skew_s;
    logic [SYS_COL-1:0]     skew_nxt_s;

    mem_skew_sreg #(
        .WIDTH (SYS_COL)
    ) u_skew (
        .clk (clk),
        .rst (rst),
        .clr (accept_s),
        .din (inj_s),
        .q   (skew_s)
    );

    // Clamp the requested row count to the depth of one bank.
    always_comb begin
        eff_rows_s = {COUNT_WIDTH{1'b0}};
        if (bus.num_row > DATA_WIDTH'(ACCUM_ROW)) begin
            eff_rows_s = COUNT_WIDTH'(ACCUM_ROW);
        end else begin
            eff_rows_s = bus.num_row[COUNT_WIDTH-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        inj_s    = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.wr_start) begin
                    accept_s = 1'b1;
                    if (eff_rows_s == {COUNT_WIDTH{1'b0}}) begin
                        state_s = IDLE;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                inj_s = bus.col0_valid && (cnt_r < eff_rows_r);
                if (inj_s && ((cnt_r + COUNT_WIDTH'(1)) == eff_rows_r)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                // Only the last column still holds a bit: the next shift empties the register.
                if (skew_s[SYS_COL-2:0] == {(SYS_COL-1){1'b0}}) begin
                    finish_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    state_s  = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign done_s     = (accept_s && (eff_rows_s == {COUNT_WIDTH{1'b0}})) || finish_s;
    assign skew_nxt_s = accept_s ? {SYS_COL{1'b0}} : {skew_s[SYS_COL-2:0], inj_s};

    // Job parameters, row counter and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= {COUNT_WIDTH{1'b0}};
            eff_rows_r <= {COUNT_WIDTH{1'b0}};
            acc_mode_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
            wr_acc_r   <= {SYS_COL{1'b0}};
        end else begin
            busy_r   <= (state_s != IDLE);
            done_r   <= done_s;
            wr_acc_r <= skew_nxt_s & {SYS_COL{acc_mode_r}};
            if (accept_s) begin
                eff_rows_r <= eff_rows_s;
                acc_mode_r <= bus.acc_mode;
                cnt_r      <= {COUNT_WIDTH{1'b0}};
                ovf_r      <= 1'b0;
            end else begin
                if (inj_s) begin
                    cnt_r <= cnt_r + COUNT_WIDTH'(1);
                end
                if ((state_r == DRAIN) && bus.col0_valid) begin
                    ovf_r <= 1'b1;
                end
            end
        end
    end

    // Per-bank address: advances after each write of that bank, parks at all-ones when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < SYS_COL; j++) begin
                addr_r[j] <= {ADDR_WIDTH{1'b1}};
            end
        end else begin
            for (int j = 0; j < SYS_COL; j++) begin
                if (accept_s) begin
                    addr_r[j] <= bus.base_addr;
                end else if (finish_s) begin
                    addr_r[j] <= {ADDR_WIDTH{1'b1}};
                end else if (skew_s[j]) begin
                    addr_r[j] <= addr_r[j] + ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign bus.wr_en_out = skew_s;
    assign bus.wr_acc    = wr_acc_r;
    assign bus.wr_addr   = addr_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_mem_wr_ctrl.sv
// Self-checking bench for mem_wr_ctrl against a cycle-indexed behavioural model of the write stream.
module tb_mem_wr_ctrl;

    localparam int SC   = 16;
    localparam int DW   = 16;
    localparam int AW   = 8;
    localparam int AR   = 256;
    localparam int HMAX = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_wr_ctrl_if #(.SYS_COL(SC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_wr_ctrl #(
        .SYS_ROW(16), .SYS_COL(SC), .DATA_WIDTH(DW), .ACCUM_SIZE(4096), .ADDR_WIDTH(AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: hist[e] = 1 when a row entered column 0 at clock edge e.
    int          ec = 0;
    bit          hist [0:HMAX-1];
    bit          m_busy, m_run, m_done, m_ovf, m_mode;
    int          m_eff, m_cnt, m_last;
    logic [7:0]  m_addr [0:SC-1];
    int          act_w  [0:SC-1];

    function automatic bit exp_en(int j);
        if (ec - j >= 0) return hist[ec - j];
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < HMAX; i++) hist[i] = 1'b0;
        m_busy = 0; m_run = 0; m_done = 0; m_ovf = 0; m_mode = 0;
        m_eff = 0; m_cnt = 0; m_last = 0;
        for (int j = 0; j < SC; j++) m_addr[j] = 8'hFF;
    endtask

    task automatic model_edge(input bit v, input bit st, input logic [15:0] nr,
                              input logic [7:0] ba, input bit am);
        ec++;
        if (ec >= HMAX - 1) begin
            $display("FAIL cycle_budget: edge %0d exceeds model history %0d", ec, HMAX);
            $fatal(1, "cycle budget exhausted");
        end
        for (int j = 0; j < SC; j++)
            if (ec - 1 - j >= 0 && hist[ec - 1 - j]) m_addr[j] = m_addr[j] + 8'd1;
        hist[ec] = 1'b0;
        m_done = 1'b0;
        if (!m_busy) begin
            if (st) begin
                m_eff = (int'(nr) > AR) ? AR : int'(nr);
                m_mode = am; m_ovf = 0; m_cnt = 0;
                for (int j = 0; j < SC; j++) m_addr[j] = ba;
                if (m_eff == 0) m_done = 1'b1;
                else begin m_busy = 1'b1; m_run = 1'b1; end
            end
        end else if (m_run) begin
            if (v && m_cnt < m_eff) begin
                hist[ec] = 1'b1;
                m_cnt++;
                if (m_cnt == m_eff) begin m_run = 1'b0; m_last = ec; end
            end
        end else begin
            if (v) m_ovf = 1'b1;
            if (ec == m_last + SC) begin
                m_busy = 1'b0; m_done = 1'b1;
                for (int j = 0; j < SC; j++) m_addr[j] = 8'hFF;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [SC-1:0] e_en;
        for (int j = 0; j < SC; j++) e_en[j] = exp_en(j);
        n_cmp++;
        assert (bus.wr_en_out === e_en) else begin
            n_bad++; $error("FAIL %s wr_en_out edge=%0d got %h exp %h", tag, ec, bus.wr_en_out, e_en);
        end
        n_cmp++;
        assert (bus.wr_acc === (e_en & {SC{m_mode}})) else begin
            n_bad++; $error("FAIL %s wr_acc edge=%0d got %h exp %h", tag, ec, bus.wr_acc, e_en & {SC{m_mode}});
        end
        n_cmp++;
        assert (bus.busy === m_busy) else begin
            n_bad++; $error("FAIL %s busy edge=%0d got %b exp %b", tag, ec, bus.busy, m_busy);
        end
        n_cmp++;
        assert (bus.done === m_done) else begin
            n_bad++; $error("FAIL %s done edge=%0d got %b exp %b", tag, ec, bus.done, m_done);
        end
        n_cmp++;
        assert (bus.ovf === m_ovf) else begin
            n_bad++; $error("FAIL %s ovf edge=%0d got %b exp %b", tag, ec, bus.ovf, m_ovf);
        end
        for (int j = 0; j < SC; j++) begin
            n_cmp++;
            assert (bus.wr_addr[j] === m_addr[j]) else begin
                n_bad++; $error("FAIL %s wr_addr[%0d] edge=%0d got %h exp %h", tag, j, ec, bus.wr_addr[j], m_addr[j]);
            end
            if (bus.wr_en_out[j] === 1'b1) act_w[j]++;
        end
    endtask

    task automatic step(input bit v, input bit st, input logic [15:0] nr,
                        input logic [7:0] ba, input bit am, input string tag);
        @(negedge clk);
        bus.col0_valid = v; bus.wr_start = st; bus.num_row = nr;
        bus.base_addr = ba; bus.acc_mode = am;
        @(posedge clk);
        model_edge(v, st, nr, ba, am);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, tag);
    endtask

    // Run until the model reports idle, then confirm the DUT is idle too.
    task automatic finish_job(input bit v, input int bound, input string tag);
        for (int i = 0; i < bound && m_busy; i++) step(v, 1'b0, 16'd0, 8'd0, 1'b0, tag);
        n_cmp++;
        assert (!m_busy && bus.busy === 1'b0) else begin
            n_bad++; $error("FAIL %s timeout: busy got %b exp 0 after %0d cycles", tag, bus.busy, bound);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        bus.col0_valid = 1'b0; bus.wr_start = 1'b0; bus.num_row = 16'd0;
        bus.base_addr = 8'd0; bus.acc_mode = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all({tag, "_async"});
        @(posedge clk);
        ec++;
        #1;
        check_all({tag, "_hold"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_counts();
        for (int j = 0; j < SC; j++) act_w[j] = 0;
    endtask

    task automatic check_writes(input int exp_n, input string tag);
        for (int j = 0; j < SC; j++) begin
            n_cmp++;
            assert (act_w[j] == exp_n) else begin
                n_bad++; $error("FAIL %s writes col%0d got %0d exp %0d", tag, j, act_w[j], exp_n);
            end
        end
    endtask

    initial begin
        bus.col0_valid = 1'b0; bus.wr_start = 1'b0; bus.num_row = 16'd0;
        bus.base_addr = 8'd0; bus.acc_mode = 1'b0;
        model_reset();
        clear_counts();
        do_reset("reset");
        idle(2, "post_reset");

        // Four rows, overwrite mode, continuous valid.
        clear_counts();
        step(1'b0, 1'b1, 16'd4, 8'h00, 1'b0, "a_start");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'd0, 8'd0, 1'b0, "a_run");
        finish_job(1'b0, 40, "a_drain");
        check_writes(4, "a");

        // Three rows, accumulate mode, valid pattern 1,0,1,1.
        clear_counts();
        step(1'b0, 1'b1, 16'd3, 8'h00, 1'b1, "b_start");
        step(1'b1, 1'b0, 16'd0, 8'd0, 1'b0, "b_run");
        step(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, "b_run");
        step(1'b1, 1'b0, 16'd0, 8'd0, 1'b0, "b_run");
        step(1'b1, 1'b0, 16'd0, 8'd0, 1'b0, "b_run");
        finish_job(1'b0, 40, "b_drain");
        check_writes(3, "b");

        // Zero rows: done only.
        step(1'b1, 1'b1, 16'd0, 8'h3C, 1'b1, "zero_start");
        idle(3, "zero_after");

        // Oversized job clamps to 256 rows and wraps addresses from 0xF0.
        clear_counts();
        step(1'b1, 1'b1, 16'd300, 8'hF0, 1'b0, "big_start");
        for (int i = 0; i < 270; i++) step(1'b1, 1'b0, 16'd0, 8'd0, 1'b0, "big_run");
        finish_job(1'b0, 40, "big_drain");
        check_writes(256, "big");
        n_cmp++;
        assert (bus.ovf === 1'b1) else begin
            n_bad++; $error("FAIL big_ovf got %b exp 1", bus.ovf);
        end

        // Reset after five rows, then a clean job.
        step(1'b0, 1'b1, 16'd10, 8'h20, 1'b1, "rst_start");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'd0, 8'd0, 1'b0, "rst_run");
        do_reset("midrun_reset");
        idle(20, "after_reset");
        clear_counts();
        step(1'b0, 1'b1, 16'd2, 8'h40, 1'b0, "clean_start");
        finish_job(1'b1, 40, "clean_job");
        check_writes(2, "clean");

        // wr_start with num_row=9 during RUN must be ignored.
        clear_counts();
        step(1'b0, 1'b1, 16'd5, 8'h80, 1'b0, "ign_start");
        step(1'b1, 1'b0, 16'd0, 8'd0, 1'b0, "ign_run");
        step(1'b1, 1'b1, 16'd9, 8'h11, 1'b1, "ign_restart");
        finish_job(1'b1, 60, "ign_drain");
        check_writes(5, "ign");

        // Randomised jobs with gappy valid, stray starts and drain-time valid.
        for (int k = 0; k < 8; k++) begin
            logic [15:0] nr;
            logic [7:0]  ba;
            bit          am;
            nr = 16'($urandom_range(0, 40));
            ba = 8'($urandom);
            am = 1'($urandom);
            step(1'($urandom), 1'b1, nr, ba, am, "rnd_start");
            for (int i = 0; i < 200 && m_busy; i++)
                step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                     16'($urandom), 8'($urandom), 1'($urandom), "rnd_run");
            n_cmp++;
            assert (!m_busy && bus.busy === 1'b0) else begin
                n_bad++; $error("FAIL rnd_timeout busy got %b exp 0", bus.busy);
            end
            idle(2, "rnd_gap");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
